// File: rtl/serial_pkg.sv
// Shared definitions for the serial framing transmitter and its receive-side checker.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Cycles occupied by one frame: start + data + optional parity + stop.
    function automatic int frame_len(input int width, input int parity_en);
        return 32'sd2 + width + parity_en;
    endfunction

endpackage

// File: rtl/frame_parity.sv
// Combinational parity of a data word; even parity is the XOR-reduction, odd is its inverse.
module frame_parity
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             odd,
    output logic             parity
);

    assign parity = (^data) ^ odd;

endmodule

// File: rtl/serial_frame_tx.sv
// Framed parallel-to-serial transmitter: start bit, data LSB-first, optional parity, stop bit.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1,
    parameter int ODD       = 0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             busy,
    output logic             frame_done
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    cnt_r;
    logic             parity_r;
    logic             sout_r;
    logic             busy_r;
    logic             done_r;
    logic             parity_s;
    logic             xfer_s;

    frame_parity #(
        .WIDTH (WIDTH)
    ) u_parity (
        .data   (din),
        .odd    (ODD != 0),
        .parity (parity_s)
    );

    // Ready in IDLE and STOP so a new word can chain onto the stop bit without a gap.
    always_comb begin
        load_ready = 1'b0;
        if (resetn && ((state_r == IDLE) || (state_r == STOP))) begin
            load_ready = 1'b1;
        end else begin
            load_ready = 1'b0;
        end
    end

    assign xfer_s = load_valid && load_ready;

    // Frame sequencer; sout is registered so each bit is presented for one full cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r  <= IDLE;
            sout_r   <= IDLE_LEVEL;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            cnt_r    <= '0;
            shreg_r  <= '0;
            parity_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, STOP: begin
                    if (xfer_s) begin
                        state_r  <= START;
                        sout_r   <= START_LEVEL;
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                        shreg_r  <= din;
                        parity_r <= parity_s;
                    end else begin
                        state_r <= IDLE;
                        sout_r  <= IDLE_LEVEL;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                START: begin
                    state_r <= DATA;
                    sout_r  <= shreg_r[0];
                    shreg_r <= shreg_r >> 1;
                    cnt_r   <= '0;
                end
                DATA: begin
                    if (cnt_r == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_r <= PARITY;
                            sout_r  <= parity_r;
                        end else begin
                            state_r <= STOP;
                            sout_r  <= STOP_LEVEL;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        sout_r  <= shreg_r[0];
                        shreg_r <= shreg_r >> 1;
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                PARITY: begin
                    state_r <= STOP;
                    sout_r  <= STOP_LEVEL;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    sout_r  <= IDLE_LEVEL;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sout       = sout_r;
    assign busy       = busy_r;
    assign frame_done = done_r;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench: three transmitter configurations compared every cycle against a frame-level model.
module tb_serial_frame_tx;

    logic       clock;
    logic       resetn;
    logic [7:0] din_a [3];
    logic       lv    [3];
    logic       rdy   [3];
    logic       so    [3];
    logic       bz    [3];
    logic       fd    [3];

    serial_frame_tx #(.WIDTH(8), .PARITY_EN(1), .ODD(0)) dut_even (
        .clock(clock), .resetn(resetn), .din(din_a[0]), .load_valid(lv[0]),
        .load_ready(rdy[0]), .sout(so[0]), .busy(bz[0]), .frame_done(fd[0]));

    serial_frame_tx #(.WIDTH(8), .PARITY_EN(1), .ODD(1)) dut_odd (
        .clock(clock), .resetn(resetn), .din(din_a[1]), .load_valid(lv[1]),
        .load_ready(rdy[1]), .sout(so[1]), .busy(bz[1]), .frame_done(fd[1]));

    serial_frame_tx #(.WIDTH(8), .PARITY_EN(0), .ODD(0)) dut_nopar (
        .clock(clock), .resetn(resetn), .din(din_a[2]), .load_valid(lv[2]),
        .load_ready(rdy[2]), .sout(so[2]), .busy(bz[2]), .frame_done(fd[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Six-stage delay line standing in for the downstream shift register.
    logic [5:0] dl;
    always @(posedge clock) dl <= {dl[4:0], so[0]};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Frame-level model: each accepted word becomes a bit array walked one position per cycle.
    int   pe_k  [3] = '{1, 1, 0};
    int   odd_k [3] = '{0, 1, 0};
    int   pos   [3];
    int   fl    [3];
    logic fr    [3][0:10];

    function automatic logic m_ready(input int k);
        return resetn && ((pos[k] < 0) || (pos[k] == fl[k] - 1));
    endfunction

    function automatic logic m_sout(input int k);
        return (pos[k] < 0) ? 1'b1 : fr[k][pos[k]];
    endfunction

    task automatic build(input int k, input logic [7:0] d);
        fl[k] = 2 + 8 + pe_k[k];
        fr[k][0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[k][1 + i] = d[i];
        if (pe_k[k] != 0) fr[k][9] = (^d) ^ (odd_k[k] != 0);
        fr[k][fl[k] - 1] = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin pos[k] = -1; fl[k] = 11; end
        forever begin
            @(posedge clock);
            for (int k = 0; k < 3; k++) begin
                if (!resetn) pos[k] = -1;
                else if (lv[k] && m_ready(k)) begin build(k, din_a[k]); pos[k] = 0; end
                else if (pos[k] >= 0) begin
                    pos[k]++;
                    if (pos[k] == fl[k]) pos[k] = -1;
                end
            end
        end
    end

    bit   chk_en = 1'b0;
    bit   rec    = 1'b0;
    int   run      [3] = '{0, 0, 0};
    int   last_run [3] = '{0, 0, 0};
    logic tr0 [$];
    logic tr1 [$];
    logic tr2 [$];
    logic trd [$];

    // Compare process on the falling edge, away from the DUT's active edge.
    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("sout[%0d]", k), so[k], m_sout(k));
                chk($sformatf("busy[%0d]", k), bz[k], pos[k] >= 0);
                chk($sformatf("frame_done[%0d]", k), fd[k], (pos[k] >= 0) && (pos[k] == fl[k] - 1));
                chk($sformatf("load_ready[%0d]", k), rdy[k], m_ready(k));
                if (bz[k]) run[k]++;
                else if (run[k] != 0) begin last_run[k] = run[k]; run[k] = 0; end
            end
        end
        if (rec) begin
            tr0.push_back(so[0]); tr1.push_back(so[1]);
            tr2.push_back(so[2]); trd.push_back(dl[5]);
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_traces();
        tr0.delete(); tr1.delete(); tr2.delete(); trd.delete();
    endtask

    logic e1 [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic e2 [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic e5 [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        resetn = 1'b0;
        for (int k = 0; k < 3; k++) begin lv[k] = 1'b0; din_a[k] = 8'h00; end
        step(); step();
        chk_en = 1'b1;
        @(negedge clock); #1;
        chk("rst_sout", so[0], 1'b1);
        chk("rst_busy", bz[0], 1'b0);
        chk("rst_done", fd[0], 1'b0);
        chk("rst_ready", rdy[0], 1'b0);
        step();
        resetn = 1'b1;
        repeat (8) step();

        // Single frame 0xA5, also observed through the delay line.
        din_a[0] = 8'hA5; lv[0] = 1'b1; step();
        lv[0] = 1'b0; clear_traces(); rec = 1'b1;
        repeat (18) step();
        rec = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk("s1_sout", tr0[i], e1[i]);
            chk("s1_delayed", trd[i + 6], e1[i]);
        end
        chk("s1_idle_after", tr0[11], 1'b1);
        chk("s1_busy_len", last_run[0], 11);

        // Back-to-back 0xA5 then 0x07 with load_valid held.
        din_a[0] = 8'hA5; lv[0] = 1'b1; step();
        din_a[0] = 8'h07;
        repeat (11) step();
        lv[0] = 1'b0; clear_traces(); rec = 1'b1;
        repeat (12) step();
        rec = 1'b0;
        for (int i = 0; i < 11; i++) chk("s2_second_frame", tr0[i], e2[i]);
        chk("s2_busy_len", last_run[0], 22);

        // Odd parity of 0x00, and a no-parity frame of 0xFF.
        din_a[1] = 8'h00; lv[1] = 1'b1; din_a[2] = 8'hFF; lv[2] = 1'b1; step();
        lv[1] = 1'b0; lv[2] = 1'b0; clear_traces(); rec = 1'b1;
        repeat (12) step();
        rec = 1'b0;
        chk("s3_odd_start", tr1[0], 1'b0);
        chk("s3_odd_parity", tr1[9], 1'b1);
        chk("s3_odd_stop", tr1[10], 1'b1);
        chk("s3_odd_busy_len", last_run[1], 11);
        chk("s3_np_start", tr2[0], 1'b0);
        for (int i = 1; i < 10; i++) chk("s3_np_bits", tr2[i], 1'b1);
        chk("s3_np_busy_len", last_run[2], 10);

        // Load attempts during DATA must be ignored.
        din_a[0] = 8'hA5; lv[0] = 1'b1; step();
        lv[0] = 1'b0; clear_traces(); rec = 1'b1;
        step();
        lv[0] = 1'b1; din_a[0] = 8'h3C;
        repeat (6) begin step(); din_a[0] = 8'($urandom); end
        lv[0] = 1'b0;
        repeat (8) step();
        rec = 1'b0;
        for (int i = 0; i < 11; i++) chk("s4_unaltered", tr0[i], e1[i]);
        @(negedge clock); #1;
        chk("s4_ready_idle", rdy[0], 1'b1);
        chk("s4_busy_idle", bz[0], 1'b0);

        // Reset during the fourth data bit, then a clean 0x5A frame.
        step();
        din_a[0] = 8'hA5; lv[0] = 1'b1; step();
        lv[0] = 1'b0;
        repeat (4) step();
        resetn = 1'b0; step();
        @(negedge clock); #1;
        chk("s5_rst_sout", so[0], 1'b1);
        chk("s5_rst_busy", bz[0], 1'b0);
        chk("s5_rst_done", fd[0], 1'b0);
        chk("s5_rst_ready", rdy[0], 1'b0);
        step();
        resetn = 1'b1;
        @(negedge clock); #1;
        chk("s5_ready_release", rdy[0], 1'b1);
        step();
        din_a[0] = 8'h5A; lv[0] = 1'b1; step();
        lv[0] = 1'b0; clear_traces(); rec = 1'b1;
        repeat (12) step();
        rec = 1'b0;
        for (int i = 0; i < 11; i++) chk("s5_new_frame", tr0[i], e5[i]);

        // Random traffic with occasional resets, checked by the model every cycle.
        repeat (600) begin
            for (int k = 0; k < 3; k++) begin
                lv[k] = ($urandom_range(0, 2) == 0);
                din_a[k] = 8'($urandom);
            end
            resetn = ($urandom_range(0, 63) != 0);
            step();
        end
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) lv[k] = 1'b0;
        repeat (15) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
